apb_mem_slave: RTL



---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_mem_array.sv | 27 ++
 rtl/apb_mem_slave.sv | 138 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB memory completer
package apb_pkg;

  // Bus byte-address bits that carry the word address
  localparam int APB_ADDR_LSB = 2;
  localparam int APB_ADDR_MSB = 11;
  localparam int APB_WORD_ADDR_W = APB_ADDR_MSB - APB_ADDR_LSB + 1;
  localparam int APB_DATA_W = 32;

  // Width of the wait-state counter (supports 0..15 wait states)
  localparam int APB_WAIT_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  typedef logic [APB_WORD_ADDR_W-1:0] apb_addr_t;
  typedef logic [APB_DATA_W-1:0]      apb_data_t;

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - single-port synchronous RAM with registered read port
module apb_mem_array #(
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One shared address: write when we, otherwise capture the read word when re
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB3 completer backed by on-chip word memory
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  // Memory index width; upper address bits only participate in the range check
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e             state_q, state_d;
  logic [APB_WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]       addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   rd_ok_q, rd_ok_d;

  logic                   in_range;
  logic                   accept_setup;
  logic                   mem_we;
  logic                   mem_re;
  logic [IDX_W-1:0]       mem_addr;
  logic [DATA_W-1:0]      mem_rdata;

  // DEPTH may equal 2**ADDR_W, so compare with one extra bit
  assign in_range = ({1'b0, paddr} < (ADDR_W + 1)'(DEPTH));

  // Completion is decoded from registered state plus the bus strobes only
  assign pready  = (state_q == ACCESS) && (wait_cnt_q == '0) && psel && penable;
  assign pslverr = pready && err_q;

  // Out-of-range reads and the reset state present zero instead of the RAM word
  assign prdata  = rd_ok_q ? mem_rdata : '0;

  // Next-state, latch and RAM-control decode for the IDLE/ACCESS handshake
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rd_ok_d      = rd_ok_q;
    accept_setup = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = paddr[IDX_W-1:0];

    case (state_q)
      IDLE: begin
        // A stray penable without a setup phase is ignored
        if (psel && !penable) begin
          accept_setup = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (!penable) begin
          // Master re-entered setup mid-access: restart as a fresh transfer
          accept_setup = 1'b1;
        end else if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end else begin
          if (write_q && !err_q && !prst) begin
            mem_we   = 1'b1;
            mem_addr = addr_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_setup) begin
      state_d    = ACCESS;
      addr_d     = paddr[IDX_W-1:0];
      write_d    = pwrite;
      wdata_d    = pwdata;
      err_d      = !in_range;
      wait_cnt_d = APB_WAIT_W'(WAIT_CYCLES);
      if (!pwrite) begin
        mem_re  = in_range;
        rd_ok_d = in_range;
      end
    end
  end

  // State and latched transfer registers; reset aborts any transfer in flight
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  apb_mem_array #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (pclk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule
